// File: rtl/dlx_tlx_pkg.sv
// Shared definitions for the DLX link model: flit and debug widths and the
// link state encoding used by the link FSM.
package dlx_tlx_pkg;

    localparam int FLIT_W  = 512;
    localparam int DEBUG_W = 36;

    typedef enum logic [1:0] {
        LINK_DOWN  = 2'd0,
        LINK_TRAIN = 2'd1,
        LINK_UP    = 2'd2
    } link_state_e;

endpackage

// File: rtl/dlx_flit_fifo.sv
// Receive flit FIFO with a registered write and a combinational head.
// Ports:
//   clock, reset     - clock and synchronous active-high reset
//   flush            - return both pointers to 0 (contents become invalid)
//   push, din        - write request and data
//   pop              - consumer takes the head
//   dout, valid      - head entry and non-empty flag
//   pop_ok           - pop was accepted this cycle (FIFO was non-empty)
//   overflow         - sticky: a push arrived while full with no pop
module dlx_flit_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 512
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             pop_ok,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             overflow_q, overflow_d;
    logic             empty, full, push_ok;

    always_comb begin
        empty      = (wr_q == rd_q);
        full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        pop_ok     = pop && !empty;
        // A pop frees the slot at full, so a same-cycle push is still accepted.
        push_ok    = push && (!full || pop_ok);
        wr_d       = wr_q + (push_ok ? (AW+1)'(1) : (AW+1)'(0));
        rd_d       = rd_q + (pop_ok  ? (AW+1)'(1) : (AW+1)'(0));
        overflow_d = overflow_q || (push && full && !pop_ok);
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q       <= '0;
            rd_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset; validity is tracked purely by the pointers.
    always_ff @(posedge clock) begin
        if (push_ok && !flush) begin
            mem_q[wr_q[AW-1:0]] <= din;
        end
    end

    assign dout     = mem_q[rd_q[AW-1:0]];
    assign valid    = !empty;
    assign overflow = overflow_q;

endmodule

// File: rtl/dlx_link_model.sv
// Behavioural DLX link model: link bring-up FSM, receive FIFO toward the
// consumer with per-pop credit return, registered transmit path toward TLX,
// and a capture register for the last nonzero TLX debug code.
// Ports:
//   clock, reset                 - clock and synchronous active-high reset
//   train_en, link_down_req      - link training permit / forced link down
//   tlx_dlx_flit_valid/_flit     - flits from TLX into the receive FIFO
//   tlx_dlx_debug_encode/_info   - TLX debug code and data
//   rx_pop, rx_flit, rx_valid    - FIFO head interface; rx_overflow sticky
//   tx_valid, tx_flit, tx_crc_err, tx_ready - BFM transmit request
//   dlx_tlx_*                    - link status, constants and flits to TLX
//   debug_last                   - {encode, info} of last nonzero debug code
//
// state      | meaning
// LINK_DOWN  | idle, waiting for train_en
// LINK_TRAIN | training, counts TRAIN_CYCLES cycles
// LINK_UP    | link up, flits accepted in both directions
module dlx_link_model
    import dlx_tlx_pkg::*;
#(
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [2:0]  INIT_CREDITS = 3'd7,
    parameter int          TRAIN_CYCLES = 16,
    parameter logic [31:0] CONFIG_INFO  = 32'h0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               train_en,
    input  logic               link_down_req,
    input  logic               tlx_dlx_flit_valid,
    input  logic [FLIT_W-1:0]  tlx_dlx_flit,
    input  logic [3:0]         tlx_dlx_debug_encode,
    input  logic [31:0]        tlx_dlx_debug_info,
    input  logic               rx_pop,
    output logic [FLIT_W-1:0]  rx_flit,
    output logic               rx_valid,
    output logic               rx_overflow,
    input  logic               tx_valid,
    input  logic [FLIT_W-1:0]  tx_flit,
    input  logic               tx_crc_err,
    output logic               tx_ready,
    output logic               dlx_tlx_link_up,
    output logic [2:0]         dlx_tlx_init_flit_depth,
    output logic [31:0]        dlx_config_info,
    output logic               dlx_tlx_flit_valid,
    output logic [FLIT_W-1:0]  dlx_tlx_flit,
    output logic               dlx_tlx_flit_crc_err,
    output logic               dlx_tlx_flit_credit,
    output logic [DEBUG_W-1:0] debug_last
);

    localparam int CW = $clog2(TRAIN_CYCLES + 1);

    link_state_e        state_q, state_d;
    logic [CW-1:0]      train_cnt_q, train_cnt_d;
    logic               link_up_q, link_up_d;
    logic               credit_q, credit_d;
    logic               flit_valid_q, flit_valid_d;
    logic               crc_err_q, crc_err_d;
    logic [FLIT_W-1:0]  flit_q, flit_d;
    logic [DEBUG_W-1:0] debug_q, debug_d;
    logic               leaving_up, fifo_push, pop_ok, tx_fire;

    always_comb begin
        state_d     = state_q;
        train_cnt_d = train_cnt_q;
        unique case (state_q)
            LINK_DOWN: begin
                if (train_en) begin
                    state_d     = LINK_TRAIN;
                    // Down-counter reaches 0 on the last of TRAIN_CYCLES cycles.
                    train_cnt_d = CW'(TRAIN_CYCLES - 1);
                end
            end
            LINK_TRAIN: begin
                if (!train_en) begin
                    state_d = LINK_DOWN;
                end else if (train_cnt_q == '0) begin
                    state_d = LINK_UP;
                end else begin
                    train_cnt_d = train_cnt_q - CW'(1);
                end
            end
            LINK_UP: ;
            default: state_d = LINK_DOWN;
        endcase
        if (link_down_req) begin
            state_d = LINK_DOWN;
        end

        leaving_up = (state_q == LINK_UP) && (state_d != LINK_UP);
        link_up_d  = (state_d == LINK_UP);
        fifo_push  = tlx_dlx_flit_valid && (state_q == LINK_UP);
        credit_d   = pop_ok && !leaving_up;

        tx_fire      = tx_valid && link_up_q;
        flit_valid_d = tx_fire && !leaving_up;
        crc_err_d    = tx_fire && tx_crc_err && !leaving_up;
        flit_d       = tx_fire ? tx_flit : flit_q;

        debug_d = (tlx_dlx_debug_encode != 4'd0)
                ? {tlx_dlx_debug_encode, tlx_dlx_debug_info} : debug_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= LINK_DOWN;
            train_cnt_q  <= '0;
            link_up_q    <= 1'b0;
            credit_q     <= 1'b0;
            flit_valid_q <= 1'b0;
            crc_err_q    <= 1'b0;
            flit_q       <= '0;
            debug_q      <= '0;
        end else begin
            state_q      <= state_d;
            train_cnt_q  <= train_cnt_d;
            link_up_q    <= link_up_d;
            credit_q     <= credit_d;
            flit_valid_q <= flit_valid_d;
            crc_err_q    <= crc_err_d;
            flit_q       <= flit_d;
            debug_q      <= debug_d;
        end
    end

    dlx_flit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FLIT_W)
    ) u_rx_fifo (
        .clock    (clock),
        .reset    (reset),
        .flush    (leaving_up),
        .push     (fifo_push),
        .din      (tlx_dlx_flit),
        .pop      (rx_pop),
        .dout     (rx_flit),
        .valid    (rx_valid),
        .pop_ok   (pop_ok),
        .overflow (rx_overflow)
    );

    assign tx_ready                = link_up_q;
    assign dlx_tlx_link_up         = link_up_q;
    assign dlx_tlx_init_flit_depth = INIT_CREDITS;
    assign dlx_config_info         = CONFIG_INFO;
    assign dlx_tlx_flit_valid      = flit_valid_q;
    assign dlx_tlx_flit            = flit_q;
    assign dlx_tlx_flit_crc_err    = crc_err_q;
    assign dlx_tlx_flit_credit     = credit_q;
    assign debug_last              = debug_q;

endmodule

// File: tb/tb_dlx_link_model.sv
module tb_dlx_link_model;
    import dlx_tlx_pkg::*;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               train_en = 1'b0;
    logic               link_down_req = 1'b0;
    logic               tlx_dlx_flit_valid = 1'b0;
    logic [FLIT_W-1:0]  tlx_dlx_flit = '0;
    logic [3:0]         tlx_dlx_debug_encode = '0;
    logic [31:0]        tlx_dlx_debug_info = '0;
    logic               rx_pop = 1'b0;
    logic [FLIT_W-1:0]  rx_flit;
    logic               rx_valid;
    logic               rx_overflow;
    logic               tx_valid = 1'b0;
    logic [FLIT_W-1:0]  tx_flit = '0;
    logic               tx_crc_err = 1'b0;
    logic               tx_ready;
    logic               dlx_tlx_link_up;
    logic [2:0]         dlx_tlx_init_flit_depth;
    logic [31:0]        dlx_config_info;
    logic               dlx_tlx_flit_valid;
    logic [FLIT_W-1:0]  dlx_tlx_flit;
    logic               dlx_tlx_flit_crc_err;
    logic               dlx_tlx_flit_credit;
    logic [DEBUG_W-1:0] debug_last;

    dlx_link_model dut (
        .clock                   (clock),
        .reset                   (reset),
        .train_en                (train_en),
        .link_down_req           (link_down_req),
        .tlx_dlx_flit_valid      (tlx_dlx_flit_valid),
        .tlx_dlx_flit            (tlx_dlx_flit),
        .tlx_dlx_debug_encode    (tlx_dlx_debug_encode),
        .tlx_dlx_debug_info      (tlx_dlx_debug_info),
        .rx_pop                  (rx_pop),
        .rx_flit                 (rx_flit),
        .rx_valid                (rx_valid),
        .rx_overflow             (rx_overflow),
        .tx_valid                (tx_valid),
        .tx_flit                 (tx_flit),
        .tx_crc_err              (tx_crc_err),
        .tx_ready                (tx_ready),
        .dlx_tlx_link_up         (dlx_tlx_link_up),
        .dlx_tlx_init_flit_depth (dlx_tlx_init_flit_depth),
        .dlx_config_info         (dlx_config_info),
        .dlx_tlx_flit_valid      (dlx_tlx_flit_valid),
        .dlx_tlx_flit            (dlx_tlx_flit),
        .dlx_tlx_flit_crc_err    (dlx_tlx_flit_crc_err),
        .dlx_tlx_flit_credit     (dlx_tlx_flit_credit),
        .debug_last              (debug_last)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [FLIT_W-1:0] f;
        logic              c;
    } tx_t;

    logic [FLIT_W-1:0] exp_rx[$];
    tx_t               exp_tx[$];
    tx_t               tx_item;
    int                n_cmp = 0;
    int                n_err = 0;
    int                credits = 0;
    logic              prev_pop = 1'b0;

    task automatic chk(input string name, input logic [FLIT_W-1:0] got,
                       input logic [FLIT_W-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [FLIT_W-1:0] pat(input int i);
        logic [31:0] w;
        w = 32'h5A5A_0000 + 32'(i);
        return {16{w}};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: checks FIFO head order on each accepted pop, credit timing,
    // and every transmit strobe against the expected-transmit queue.
    always @(negedge clock) begin
        if (!reset) begin
            if (dlx_tlx_flit_credit) begin
                credits++;
                chk("credit_follows_pop", 512'(prev_pop), 512'(1'b1));
            end
            prev_pop = rx_pop && rx_valid;
            if (rx_pop && rx_valid) begin
                if (exp_rx.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rx_unexpected_pop: got %0h want none", rx_flit);
                end else begin
                    chk("rx_order", rx_flit, exp_rx.pop_front());
                end
            end
            if (dlx_tlx_flit_valid) begin
                if (exp_tx.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL tx_unexpected_strobe: got %0h want none", dlx_tlx_flit);
                end else begin
                    tx_item = exp_tx.pop_front();
                    chk("tx_flit", dlx_tlx_flit, tx_item.f);
                    chk("tx_crc_err", 512'(dlx_tlx_flit_crc_err), 512'(tx_item.c));
                end
            end
        end else begin
            prev_pop = 1'b0;
        end
    end

    initial begin
        int n;
        int base;
        logic [FLIT_W-1:0] a5;
        a5 = {64{8'hA5}};

        repeat (3) tick();
        chk("rst_link_up",     512'(dlx_tlx_link_up), 512'(0));
        chk("rst_rx_valid",    512'(rx_valid), 512'(0));
        chk("rst_overflow",    512'(rx_overflow), 512'(0));
        chk("rst_credit",      512'(dlx_tlx_flit_credit), 512'(0));
        chk("rst_flit_valid",  512'(dlx_tlx_flit_valid), 512'(0));
        chk("rst_crc_err",     512'(dlx_tlx_flit_crc_err), 512'(0));
        chk("rst_flit",        dlx_tlx_flit, 512'(0));
        chk("rst_debug_last",  512'(debug_last), 512'(0));
        chk("rst_init_depth",  512'(dlx_tlx_init_flit_depth), 512'(7));
        chk("rst_config_info", 512'(dlx_config_info), 512'(0));
        chk("rst_tx_ready",    512'(tx_ready), 512'(0));

        reset = 1'b0;
        tick();
        chk("idle_link_up", 512'(dlx_tlx_link_up), 512'(0));

        // Training latency
        train_en = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!dlx_tlx_link_up && n < 40);
        chk("train_latency", 512'(n), 512'(17));
        chk("up_init_depth", 512'(dlx_tlx_init_flit_depth), 512'(7));
        chk("up_tx_ready", 512'(tx_ready), 512'(1));

        // Debug capture ignores zero encodes
        tlx_dlx_debug_encode = 4'h3;
        tlx_dlx_debug_info   = 32'hDEAD_BEEF;
        tick();
        tlx_dlx_debug_encode = 4'h0;
        tlx_dlx_debug_info   = 32'h1234_5678;
        tick();
        chk("debug_last", 512'(debug_last), 512'({4'h3, 32'hDEAD_BEEF}));

        // Transmit while UP
        tx_valid = 1'b1; tx_flit = a5; tx_crc_err = 1'b1;
        exp_tx.push_back('{f: a5, c: 1'b1});
        tick();
        tx_flit = pat(99); tx_crc_err = 1'b0;
        exp_tx.push_back('{f: pat(99), c: 1'b0});
        tick();
        tx_valid = 1'b0;
        tick();
        tick();
        chk("tx_hold_flit", dlx_tlx_flit, pat(99));
        chk("tx_idle_valid", 512'(dlx_tlx_flit_valid), 512'(0));

        // 7 flits then 7 pops
        for (int i = 0; i < 7; i++) begin
            tlx_dlx_flit_valid = 1'b1; tlx_dlx_flit = pat(i);
            exp_rx.push_back(pat(i));
            tick();
        end
        tlx_dlx_flit_valid = 1'b0;
        base = credits;
        rx_pop = 1'b1;
        repeat (7) tick();
        rx_pop = 1'b0;
        tick();
        tick();
        chk("seven_credits", 512'(credits - base), 512'(7));
        chk("drained_rx_valid", 512'(rx_valid), 512'(0));

        // Pop while empty gives no credit
        base = credits;
        rx_pop = 1'b1;
        tick();
        rx_pop = 1'b0;
        tick();
        tick();
        chk("empty_pop_no_credit", 512'(credits - base), 512'(0));

        // Fill to full, then push+pop together
        for (int i = 0; i < 8; i++) begin
            tlx_dlx_flit_valid = 1'b1; tlx_dlx_flit = pat(10 + i);
            exp_rx.push_back(pat(10 + i));
            tick();
        end
        base = credits;
        tlx_dlx_flit = pat(20);
        exp_rx.push_back(pat(20));
        rx_pop = 1'b1;
        tick();
        tlx_dlx_flit_valid = 1'b0;
        rx_pop = 1'b0;
        tick();
        chk("full_pushpop_no_ovf", 512'(rx_overflow), 512'(0));
        chk("full_pushpop_credit", 512'(credits - base), 512'(1));
        n = 0;
        do begin
            rx_pop = 1'b1;
            tick();
            n++;
        end while (rx_valid && n < 12);
        rx_pop = 1'b0;
        chk("full_pushpop_occupancy", 512'(n), 512'(8));

        // Overflow: 9 flits, 9th dropped
        for (int i = 0; i < 9; i++) begin
            tlx_dlx_flit_valid = 1'b1; tlx_dlx_flit = pat(30 + i);
            if (i < 8) exp_rx.push_back(pat(30 + i));
            tick();
        end
        tlx_dlx_flit_valid = 1'b0;
        tick();
        chk("overflow_set", 512'(rx_overflow), 512'(1));
        chk("overflow_head", rx_flit, pat(30));
        n = 0;
        do begin
            rx_pop = 1'b1;
            tick();
            n++;
        end while (rx_valid && n < 12);
        rx_pop = 1'b0;
        chk("overflow_occupancy", 512'(n), 512'(8));
        chk("overflow_sticky", 512'(rx_overflow), 512'(1));

        // Link down with 3 flits buffered and a pop in the same cycle
        for (int i = 0; i < 3; i++) begin
            tlx_dlx_flit_valid = 1'b1; tlx_dlx_flit = pat(40 + i);
            exp_rx.push_back(pat(40 + i));
            tick();
        end
        tlx_dlx_flit_valid = 1'b0;
        tick();
        base = credits;
        rx_pop = 1'b1;
        link_down_req = 1'b1;
        train_en = 1'b0;
        tick();
        rx_pop = 1'b0;
        link_down_req = 1'b0;
        exp_rx.delete();
        chk("down_link_up", 512'(dlx_tlx_link_up), 512'(0));
        chk("down_rx_valid", 512'(rx_valid), 512'(0));
        chk("down_tx_ready", 512'(tx_ready), 512'(0));
        repeat (3) tick();
        chk("down_no_credit", 512'(credits - base), 512'(0));

        // Transmit while DOWN produces no strobe
        tx_valid = 1'b1; tx_flit = a5; tx_crc_err = 1'b1;
        tick();
        tx_valid = 1'b0; tx_crc_err = 1'b0;
        chk("down_tx_no_strobe", 512'(dlx_tlx_flit_valid), 512'(0));
        tick();
        tick();

        chk("tx_queue_empty", 512'(exp_tx.size()), 512'(0));
        chk("rx_queue_empty", 512'(exp_rx.size()), 512'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dlx_link_model.md
DLX_LINK_MODEL -- requirements
Module: dlx_link_model

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, receive-FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter INIT_CREDITS, default 3'd7, value driven on dlx_tlx_init_flit_depth (1..7, and not above FIFO_DEPTH).
REQ-003 SHALL have parameter TRAIN_CYCLES, default 16, cycles spent in TRAIN state.
REQ-004 SHALL have parameter CONFIG_INFO, default 32'h0, value driven on dlx_config_info.
REQ-005 SHALL run on one clock, with a synchronous, active-high reset.
REQ-006 SHALL have ports, one per line (name, direction, width, meaning):
- clock  in  1  sole clock.
- reset  in  1  synchronous active-high reset.
- train_en  in  1  permits link training.
- link_down_req  in  1  forces the link down.
- tlx_dlx_flit_valid  in  1  TLX flit strobe.
- tlx_dlx_flit  in  512  TLX flit.
- tlx_dlx_debug_encode  in  4  TLX debug code.
- tlx_dlx_debug_info  in  32  TLX debug data.
- rx_pop  in  1  consumer takes the FIFO head.
- rx_flit  out  512  FIFO head.
- rx_valid  out  1  FIFO non-empty.
- rx_overflow  out  1  sticky overflow flag.
- tx_valid  in  1  BFM flit request.
- tx_flit  in  512  BFM flit.
- tx_crc_err  in  1  inject a CRC error with this flit.
- tx_ready  out  1  transmit accepted this cycle.
- dlx_tlx_link_up  out  1  link up.
- dlx_tlx_init_flit_depth  out  3  initial credits.
- dlx_config_info  out  32  constant config.
- dlx_tlx_flit_valid  out  1  flit strobe to TLX.
- dlx_tlx_flit  out  512  flit to TLX.
- dlx_tlx_flit_crc_err  out  1  CRC error marker.
- dlx_tlx_flit_credit  out  1  one-credit return pulse.
- debug_last  out  36  {encode, info} of the last nonzero TLX debug code.

Function
REQ-007 The link FSM SHALL have states DOWN, TRAIN and UP.
- DOWN->TRAIN when train_en=1.
- TRAIN->UP after exactly TRAIN_CYCLES cycles in TRAIN.
- TRAIN->DOWN if train_en drops.
- Any state->DOWN when link_down_req=1; link_down_req has priority over every other transition.
REQ-008 dlx_tlx_link_up SHALL be registered, equal to 1 only in UP, and rise on the first cycle the FSM is in UP.
REQ-009 dlx_tlx_init_flit_depth and dlx_config_info SHALL be constant parameter values at all times, including during reset.
REQ-010 While UP, each tlx_dlx_flit_valid=1 cycle SHALL write tlx_dlx_flit into the FIFO; flits arriving outside UP SHALL be ignored.
REQ-011 rx_flit/rx_valid SHALL present the FIFO head combinationally from storage; write-to-rx_valid latency is 1 cycle.
REQ-012 An rx_pop while rx_valid=1 SHALL remove the head and produce dlx_tlx_flit_credit=1 on the next cycle (one pulse per pop).
- rx_pop while empty SHALL be ignored and SHALL produce no credit.
REQ-013 A simultaneous push and pop SHALL be legal at any occupancy, including full; occupancy is unchanged.
REQ-014 A write when full with no pop SHALL drop the flit and set rx_overflow, which stays set until reset.
REQ-015 Read/write pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH.
- full = MSBs differ and the rest are equal; empty = pointers equal.
REQ-016 tx_ready SHALL equal dlx_tlx_link_up.
- When tx_valid and tx_ready are both 1, the next cycle SHALL drive dlx_tlx_flit_valid=1, dlx_tlx_flit=tx_flit and dlx_tlx_flit_crc_err=tx_crc_err.
- Otherwise dlx_tlx_flit_valid=0, dlx_tlx_flit_crc_err=0, and dlx_tlx_flit holds its value.
REQ-017 debug_last SHALL capture {tlx_dlx_debug_encode, tlx_dlx_debug_info} on every cycle where the encode is nonzero.
REQ-018 Leaving UP SHALL flush the FIFO (pointers to 0), suppress any pending credit pulse, and force dlx_tlx_flit_valid=0 next cycle.

Reset
REQ-019 Reset SHALL put the FSM in DOWN and clear the train counter and FIFO pointers.
REQ-020 Reset SHALL drive to 0: dlx_tlx_link_up, dlx_tlx_flit_valid, dlx_tlx_flit_crc_err, dlx_tlx_flit_credit, rx_overflow, dlx_tlx_flit and debug_last.
REQ-021 Reset asserted mid-transfer SHALL take effect on the next edge and override all other inputs.

Structure
REQ-022 The FSM state enum and the 512/36-bit width constants SHALL live in the shared package dlx_tlx_pkg.
REQ-023 The receive FIFO SHALL be a sub-module, dlx_flit_fifo, parameterized by depth and width.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset, then train_en=1 with TRAIN_CYCLES=16 -> link_up rises 17 cycles after train_en (1 cycle DOWN->TRAIN plus 16 in TRAIN); init_flit_depth=7 throughout.
- 7 TLX flits while UP, then 7 pops -> rx_flit order matches; exactly 7 credit pulses, each 1 cycle after its pop.
- FIFO_DEPTH=8: 9 flits with no pop -> rx_overflow=1, 9th flit dropped, head equals flit 1.
- Full FIFO with push+pop in the same cycle -> occupancy stays 8, no overflow, 1 credit pulse.
- tx_valid with flit A5.., crc_err=1 while UP -> next cycle dlx_tlx_flit_valid=1, flit=A5.., crc_err=1; same request while DOWN -> no strobe.
- link_down_req with 3 flits buffered -> link_up=0, rx_valid=0 next cycle, no credits emitted.
